// File: rtl/wave_seq_pkg.sv
// Shared types and default sizing for the waveform phase sequencer.
package wave_seq_pkg;

  localparam int NUM_PHASES_DEF = 4;
  localparam int DWELL_W_DEF    = 16;
  localparam int LOOP_W_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/wave_dwell_counter.sv
// Loadable down-counter that times how many accepted samples a phase still owes.
module wave_dwell_counter
  import wave_seq_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] value,
  output logic               is_one
);

  logic [DWELL_W-1:0] cnt_r;

  // Load wins over decrement; the count holds when neither is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {DWELL_W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (en) begin
      cnt_r <= cnt_r - DWELL_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign is_one = (cnt_r == DWELL_W'(1));

endmodule

// File: rtl/wave_phase_sequencer.sv
// Steps the generator bank through programmed phases, each enabled for a fixed
// number of accepted sample cycles, repeating for a programmed number of passes.
module wave_phase_sequencer
  import wave_seq_pkg::*;
#(
  parameter int NUM_PHASES = NUM_PHASES_DEF,
  parameter int DWELL_W    = DWELL_W_DEF,
  parameter int LOOP_W     = LOOP_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_PHASES*DWELL_W-1:0] cfg_dwell,
  input  logic [LOOP_W-1:0]             cfg_loops,
  input  logic                          cap_ready,
  output logic                          busy,
  output logic [$clog2(NUM_PHASES)-1:0] phase_sel,
  output logic                          gen_en,
  output logic                          phase_first,
  output logic [LOOP_W-1:0]             loop_idx,
  output logic                          done,
  output logic                          done_abort
);

  localparam int PHASE_W = $clog2(NUM_PHASES);

  seq_state_e                         state_r, state_s;
  logic [PHASE_W-1:0]                 phase_sel_r, phase_s;
  logic [LOOP_W-1:0]                  loop_idx_r, loop_s, loop_inc_s;
  logic [NUM_PHASES-1:0][DWELL_W-1:0] dwell_snap_r;
  logic [LOOP_W-1:0]                  loops_snap_r;
  logic [DWELL_W-1:0]                 cur_dwell_s;
  logic                               phase_first_r, done_r, done_abort_r;
  logic                               snap_s, cnt_load_s, cnt_en_s, cnt_is_one_s;
  logic                               advance_s, abort_hit_s;

  assign cur_dwell_s = dwell_snap_r[phase_sel_r];
  assign loop_inc_s  = loop_idx_r + LOOP_W'(1);

  wave_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load_s),
    .en     (cnt_en_s),
    .value  (cur_dwell_s),
    .is_one (cnt_is_one_s)
  );

  // Next-state, phase/pass stepping and counter control.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_sel_r;
    loop_s      = loop_idx_r;
    snap_s      = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_en_s    = 1'b0;
    advance_s   = 1'b0;
    abort_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s = LOAD;
          snap_s  = 1'b1;
          phase_s = {PHASE_W{1'b0}};
          loop_s  = {LOOP_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_s     = DONE;
          abort_hit_s = 1'b1;
        end else begin
          cnt_load_s = 1'b1;
          // A zero dwell skips the slot without spending a RUN cycle.
          if (cur_dwell_s != {DWELL_W{1'b0}}) begin
            state_s = RUN;
          end else begin
            advance_s = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_s     = DONE;
          abort_hit_s = 1'b1;
        end else if (cap_ready) begin
          cnt_en_s  = 1'b1;
          advance_s = cnt_is_one_s;
        end else begin
          cnt_en_s = 1'b0;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (advance_s) begin
      if (phase_sel_r < PHASE_W'(NUM_PHASES - 1)) begin
        phase_s = phase_sel_r + PHASE_W'(1);
        state_s = LOAD;
      end else begin
        phase_s = {PHASE_W{1'b0}};
        loop_s  = loop_inc_s;
        // A zero loop count never terminates; loop_idx simply wraps.
        if ((loops_snap_r != {LOOP_W{1'b0}}) && (loop_inc_s == loops_snap_r)) begin
          state_s = DONE;
        end else begin
          state_s = LOAD;
        end
      end
    end else begin
      phase_s = phase_s;
    end
  end

  // State, phase, pass and configuration snapshot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      phase_sel_r  <= {PHASE_W{1'b0}};
      loop_idx_r   <= {LOOP_W{1'b0}};
      dwell_snap_r <= {(NUM_PHASES*DWELL_W){1'b0}};
      loops_snap_r <= {LOOP_W{1'b0}};
    end else begin
      state_r     <= state_s;
      phase_sel_r <= phase_s;
      loop_idx_r  <= loop_s;
      if (snap_s) begin
        dwell_snap_r <= cfg_dwell;
        loops_snap_r <= cfg_loops;
      end else begin
        dwell_snap_r <= dwell_snap_r;
        loops_snap_r <= loops_snap_r;
      end
    end
  end

  // Registered pulse outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_first_r <= 1'b0;
      done_r        <= 1'b0;
      done_abort_r  <= 1'b0;
    end else begin
      phase_first_r <= (state_r == LOAD) && (state_s == RUN);
      done_r        <= (state_s == DONE);
      done_abort_r  <= abort_hit_s;
    end
  end

  assign busy        = (state_r != IDLE);
  assign phase_sel   = phase_sel_r;
  assign loop_idx    = loop_idx_r;
  assign phase_first = phase_first_r;
  assign done        = done_r;
  assign done_abort  = done_abort_r;
  assign gen_en      = (state_r == RUN) && cap_ready && !abort;

endmodule

// File: tb/tb_wave_phase_sequencer.sv
// Randomised and directed bench for wave_phase_sequencer against a timeline model.
module tb_wave_phase_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [63:0] cfg_dwell;
  logic [7:0]  cfg_loops;
  logic        cap_ready;
  logic        busy;
  logic [1:0]  phase_sel;
  logic        gen_en;
  logic        phase_first;
  logic [7:0]  loop_idx;
  logic        done;
  logic        done_abort;

  int checks = 0;
  int errors = 0;

  int exp_gen[$];
  int exp_cyc[$];
  int exp_done;
  int obs_gen[$];
  int obs_cyc[$];
  int obs_ps[$];
  int obs_busy[$];
  int obs_ge[$];
  int obs_done_cyc, obs_done_cnt, obs_done_abort, obs_done_loop, obs_done_phase;
  int obs_pf, obs_idle_after, obs_busy_cnt;

  wave_phase_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .cfg_dwell   (cfg_dwell),
    .cfg_loops   (cfg_loops),
    .cap_ready   (cap_ready),
    .busy        (busy),
    .phase_sel   (phase_sel),
    .gen_en      (gen_en),
    .phase_first (phase_first),
    .loop_idx    (loop_idx),
    .done        (done),
    .done_abort  (done_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dw4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Timeline with cap_ready always high: start in cycle 0, first LOAD in cycle 1.
  // Entries are loop*16+phase for every enabled sample cycle.
  function automatic void build(input logic [63:0] dw, input int lp, input int abort_at);
    int t;
    int l;
    int d;
    exp_gen.delete();
    exp_cyc.delete();
    exp_done = -1;
    t = 1;
    l = 0;
    while (exp_done < 0 && l < 4096) begin
      for (int p = 0; p < 4 && exp_done < 0; p++) begin
        d = int'(dw[p*16 +: 16]);
        if (t >= abort_at) begin
          exp_done = abort_at + 1;
        end else begin
          t++;
          for (int k = 0; k < d && exp_done < 0; k++) begin
            if (t >= abort_at) begin
              exp_done = abort_at + 1;
            end else begin
              exp_gen.push_back((l % 256) * 16 + p);
              exp_cyc.push_back(t);
              t++;
            end
          end
        end
      end
      l++;
      if (exp_done < 0 && lp != 0 && l == lp) exp_done = t;
    end
  endfunction

  function automatic int gen_diff();
    if (obs_gen.size() != exp_gen.size()) return obs_gen.size();
    foreach (exp_gen[i]) if (obs_gen[i] != exp_gen[i]) return i;
    return -1;
  endfunction

  function automatic int cyc_diff();
    if (obs_cyc.size() != exp_cyc.size()) return obs_cyc.size();
    foreach (exp_cyc[i]) if (obs_cyc[i] != exp_cyc[i]) return i;
    return -1;
  endfunction

  // Drives one sequence from start and records what the DUT shows each cycle.
  task automatic run_seq(input logic [63:0] dw, input logic [7:0] lp, input int ready_pct,
                         input int stall_lo, input int stall_hi, input int abort_at,
                         input int chg_at, input int max_cyc);
    bit stop;
    obs_gen.delete(); obs_cyc.delete(); obs_ps.delete(); obs_busy.delete(); obs_ge.delete();
    obs_done_cyc = -1; obs_done_cnt = 0; obs_done_abort = 0; obs_done_loop = -1;
    obs_done_phase = -1; obs_pf = 0; obs_idle_after = 0; obs_busy_cnt = 0;
    stop = 1'b0;
    cfg_dwell = dw;
    cfg_loops = lp;
    for (int c = 0; c < max_cyc; c++) begin
      start = (c == 0);
      abort = (c == abort_at);
      if (c >= stall_lo && c <= stall_hi) cap_ready = 1'b0;
      else if (ready_pct >= 100) cap_ready = 1'b1;
      else cap_ready = ($urandom_range(0, 99) < ready_pct);
      if (c == chg_at) begin
        cfg_dwell = {$urandom(), $urandom()};
        cfg_loops = 8'($urandom_range(1, 255));
      end
      @(negedge clk);
      obs_ps.push_back(int'(phase_sel));
      obs_busy.push_back(int'(busy));
      obs_ge.push_back(int'(gen_en));
      if (busy) obs_busy_cnt++;
      if (phase_first) obs_pf++;
      if (gen_en) begin
        obs_gen.push_back(int'(loop_idx) * 16 + int'(phase_sel));
        obs_cyc.push_back(c);
      end
      if (obs_done_cyc >= 0 && c == obs_done_cyc + 1) begin
        obs_idle_after = int'(!busy);
        stop = 1'b1;
      end
      if (done) begin
        obs_done_cnt++;
        obs_done_cyc   = c;
        obs_done_abort = int'(done_abort);
        obs_done_loop  = int'(loop_idx);
        obs_done_phase = int'(phase_sel);
      end
      @(posedge clk);
      #1;
      if (stop) break;
    end
    start = 1'b0;
    abort = 1'b0;
    cap_ready = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    cap_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, phase_sel, phase_first, loop_idx, done, done_abort} !== '0)
      $display("FAIL reset_regs got %b want all zero",
               {busy, phase_sel, phase_first, loop_idx, done, done_abort});
    checks++;
    if (gen_en !== 1'b0) $display("FAIL reset_gen_en got %b want 0", gen_en);
    if ({busy, phase_sel, phase_first, loop_idx, done, done_abort} !== '0 || gen_en !== 1'b0)
      errors++;
    @(posedge clk);
    #1;
    start = 1'b0;
    cap_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_phase_order();
    int dg;
    int dc;
    build(dw4(3, 2, 0, 1), 1, 1 << 30);
    run_seq(dw4(3, 2, 0, 1), 8'd1, 100, -1, -1, -1, -1, 60);
    dg = gen_diff();
    dc = cyc_diff();
    checks++;
    if (dg >= 0) begin errors++; $display("FAIL t1_gen_seq first diff idx %0d got %0d want %0d entries", dg, obs_gen.size(), exp_gen.size()); end
    checks++;
    if (dc >= 0) begin errors++; $display("FAIL t1_gen_cycles first diff idx %0d", dc); end
    checks++;
    if (obs_done_cyc !== 11) begin errors++; $display("FAIL t1_done_cycle got %0d want 11", obs_done_cyc); end
    checks++;
    if (obs_done_abort !== 0 || obs_done_cnt !== 1) begin errors++; $display("FAIL t1_done_flags abort %0d count %0d want 0 1", obs_done_abort, obs_done_cnt); end
    checks++;
    if (obs_pf !== 3) begin errors++; $display("FAIL t1_phase_first got %0d want 3", obs_pf); end
    checks++;
    if (obs_ps.size() < 9 || obs_busy[8] * 100 + obs_ps[8] * 10 + obs_ge[8] !== 120) begin
      errors++; $display("FAIL t1_skip_load cycle 8 not LOAD of slot 2");
    end
    checks++;
    if (obs_idle_after !== 1) begin errors++; $display("FAIL t1_idle_after got %0d want 1", obs_idle_after); end
  endtask

  task automatic test_stall();
    int dc;
    build(dw4(4, 0, 0, 0), 1, 1 << 30);
    exp_cyc = '{2, 5, 6, 7};
    run_seq(dw4(4, 0, 0, 0), 8'd1, 100, 3, 4, -1, -1, 60);
    dc = cyc_diff();
    checks++;
    if (gen_diff() >= 0) begin errors++; $display("FAIL t2_gen_seq got %0d entries want %0d", obs_gen.size(), exp_gen.size()); end
    checks++;
    if (dc >= 0) begin errors++; $display("FAIL t2_gen_cycles first diff idx %0d", dc); end
    checks++;
    if (obs_pf !== 1) begin errors++; $display("FAIL t2_phase_first got %0d want 1", obs_pf); end
    checks++;
    if (obs_done_cyc !== 11) begin errors++; $display("FAIL t2_done_cycle got %0d want 11", obs_done_cyc); end
  endtask

  task automatic test_abort();
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL t3_start_with_abort busy got %b want 0", busy); end
    @(posedge clk);
    #1;
    build(dw4(2, 2, 2, 2), 0, 20);
    run_seq(dw4(2, 2, 2, 2), 8'd0, 100, -1, -1, 20, -1, 60);
    checks++;
    if (gen_diff() >= 0) begin errors++; $display("FAIL t3_gen_seq got %0d entries want %0d", obs_gen.size(), exp_gen.size()); end
    checks++;
    if (obs_done_cyc !== exp_done) begin errors++; $display("FAIL t3_done_cycle got %0d want %0d", obs_done_cyc, exp_done); end
    checks++;
    if (obs_done_abort !== 1) begin errors++; $display("FAIL t3_done_abort got %0d want 1", obs_done_abort); end
    checks++;
    if (obs_idle_after !== 1) begin errors++; $display("FAIL t3_idle_after got %0d want 1", obs_idle_after); end
  endtask

  task automatic test_loops();
    build(dw4(1, 1, 1, 1), 3, 1 << 30);
    run_seq(dw4(1, 1, 1, 1), 8'd3, 100, -1, -1, -1, -1, 80);
    checks++;
    if (gen_diff() >= 0) begin errors++; $display("FAIL t4_gen_seq got %0d entries want %0d", obs_gen.size(), exp_gen.size()); end
    checks++;
    if (obs_done_cyc !== exp_done) begin errors++; $display("FAIL t4_done_cycle got %0d want %0d", obs_done_cyc, exp_done); end
    checks++;
    if (obs_done_loop !== 3 || obs_done_phase !== 0) begin
      errors++; $display("FAIL t4_end_indices loop %0d phase %0d want 3 0", obs_done_loop, obs_done_phase);
    end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    dn = 0;
    cfg_dwell = dw4(3, 4, 2, 2);
    cfg_loops = 8'd1;
    cap_ready = 1'b1;
    abort = 1'b0;
    for (int c = 0; c < 12; c++) begin
      start = (c == 0 || c == 7);
      reset = (c == 8);
      @(negedge clk);
      if (done) dn++;
      if (c == 8) begin
        checks++;
        if ({busy, gen_en, phase_sel} !== 4'b1101) begin
          errors++; $display("FAIL t5_start_while_busy got %b want 1101", {busy, gen_en, phase_sel});
        end
      end
      if (c >= 9) begin
        checks++;
        if ({busy, gen_en, phase_sel, phase_first, loop_idx, done, done_abort} !== '0) begin
          errors++; $display("FAIL t5_after_reset cycle %0d got %b want zero", c,
                             {busy, gen_en, phase_sel, phase_first, loop_idx, done, done_abort});
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    cap_ready = 1'b0;
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL t5_no_done got %0d pulses want 0", dn); end
  endtask

  task automatic test_all_zero();
    run_seq(dw4(0, 0, 0, 0), 8'd2, 100, -1, -1, -1, 2, 60);
    checks++;
    if (obs_gen.size() !== 0) begin errors++; $display("FAIL t6_gen_count got %0d want 0", obs_gen.size()); end
    checks++;
    if (obs_done_cyc !== 9) begin errors++; $display("FAIL t6_done_cycle got %0d want 9", obs_done_cyc); end
    checks++;
    if (obs_busy_cnt !== 9) begin errors++; $display("FAIL t6_busy_cycles got %0d want 9", obs_busy_cnt); end
  endtask

  task automatic test_random();
    logic [63:0] dw;
    int lp;
    int pct;
    int nz;
    for (int it = 0; it < 8; it++) begin
      dw = dw4($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      lp = $urandom_range(1, 3);
      pct = (it % 2 == 0) ? 100 : 50;
      nz = 0;
      for (int p = 0; p < 4; p++) if (dw[p*16 +: 16] != 16'd0) nz++;
      build(dw, lp, 1 << 30);
      run_seq(dw, 8'(lp), pct, -1, -1, -1, 1, 400);
      checks++;
      if (gen_diff() >= 0) begin errors++; $display("FAIL rnd%0d_gen_seq got %0d entries want %0d", it, obs_gen.size(), exp_gen.size()); end
      checks++;
      if (obs_done_cnt !== 1 || obs_done_loop !== lp || obs_done_abort !== 0) begin
        errors++; $display("FAIL rnd%0d_done count %0d loop %0d abort %0d want 1 %0d 0", it, obs_done_cnt, obs_done_loop, obs_done_abort, lp);
      end
      checks++;
      if (obs_pf !== lp * nz) begin errors++; $display("FAIL rnd%0d_phase_first got %0d want %0d", it, obs_pf, lp * nz); end
      if (pct == 100) begin
        checks++;
        if (obs_done_cyc !== exp_done) begin errors++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", it, obs_done_cyc, exp_done); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cap_ready = 1'b0;
    cfg_dwell = 64'd0;
    cfg_loops = 8'd0;
    test_reset();
    test_phase_order();
    test_stall();
    test_abort();
    test_loops();
    test_reset_mid_run();
    test_all_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
